// File: rtl/aib_csr_avmm_responder.sv
// Avalon-MM responder for the per-channel AIB calibration CSRs.
// Define AIB_CSR_LOCK_SYNC_EN to pass soc_clk_lock through a 2-flop synchronizer.
module aib_csr_avmm_responder #(
    parameter int NUM_CH      = 24,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [16:0]       avmm_address,
    input  logic [31:0]       avmm_writedata,
    input  logic [3:0]        avmm_byteenable,
    input  logic              avmm_write,
    input  logic              avmm_read,
    output logic              avmm_waitrequest,
    output logic [31:0]       avmm_readdata,
    output logic              avmm_readdatavalid,
    input  logic [NUM_CH-1:0] soc_clk_lock,
    output logic [7:0]        err_count
);

    localparam int         CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [6:0] NUM_CH_L  = 7'(NUM_CH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_RDATA
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [5:0]  ch_q;
    logic [10:0] off_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wr_q;
    logic        both_q;
    logic        waitreq_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [7:0]  err_q;
    logic [31:0] regs_q [NUM_CH][4];

    logic [NUM_CH-1:0] lock_w;
    logic [CHW-1:0]    ch_idx;
    logic [1:0]        idx;
    logic              off_ok;
    logic              hit;
    logic              req;
    logic              err_inc;
    logic [31:0]       old_w;
    logic [31:0]       wmerge_d;
    logic [31:0]       rdata_d;

`ifdef AIB_CSR_LOCK_SYNC_EN
    logic [NUM_CH-1:0] lock_m_q;
    logic [NUM_CH-1:0] lock_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m_q <= '0;
            lock_s_q <= '0;
        end else begin
            lock_m_q <= soc_clk_lock;
            lock_s_q <= lock_m_q;
        end
    end

    assign lock_w = lock_s_q;
`else
    assign lock_w = soc_clk_lock;
`endif

    assign req    = avmm_read | avmm_write;
    assign ch_idx = ch_q[CHW-1:0];

    always_comb begin
        off_ok = 1'b1;
        idx    = 2'd0;
        unique case (1'b1)
            (off_q == 11'h33C): idx = 2'd0;
            (off_q == 11'h344): idx = 2'd1;
            (off_q == 11'h34C): idx = 2'd2;
            (off_q == 11'h350): idx = 2'd3;
            default:            off_ok = 1'b0;
        endcase
    end

    assign hit = off_ok && ({1'b0, ch_q} < NUM_CH_L);

    // R344[27] is the live lock status: never stored, always substituted on read
    always_comb begin
        old_w    = hit ? regs_q[ch_idx][idx] : 32'h0;
        wmerge_d = old_w;
        for (int n = 0; n < 4; n++) begin
            if (be_q[n]) wmerge_d[8*n +: 8] = wdata_q[8*n +: 8];
        end
        if (idx == 2'd1) wmerge_d[27] = 1'b0;
        rdata_d = old_w;
        if (hit && idx == 2'd1) rdata_d[27] = lock_w[ch_idx];
    end

    assign err_inc = ((state_q == S_WAIT) && !req) ||
                     ((state_q == S_ACK) && (!hit || both_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wr_q      <= 1'b0;
            both_q    <= 1'b0;
            waitreq_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int r = 0; r < 4; r++) regs_q[c][r] <= '0;
            end
        end else begin
            waitreq_q <= 1'b1;
            rvalid_q  <= 1'b0;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        ch_q    <= avmm_address[16:11];
                        off_q   <= avmm_address[10:0];
                        wdata_q <= avmm_writedata;
                        be_q    <= avmm_byteenable;
                        wr_q    <= avmm_write;
                        both_q  <= avmm_write & avmm_read;
                        cnt_q   <= WAIT_INIT;
                        if (WAIT_INIT == 4'd0) begin
                            state_q   <= S_ACK;
                            waitreq_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!req) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q <= 4'd1) begin
                        state_q   <= S_ACK;
                        waitreq_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    if (wr_q) begin
                        if (hit) regs_q[ch_idx][idx] <= wmerge_d;
                        state_q <= S_IDLE;
                    end else begin
                        rdata_q  <= rdata_d;
                        rvalid_q <= 1'b1;
                        state_q  <= S_RDATA;
                    end
                end
                S_RDATA: state_q <= S_IDLE;
            endcase
        end
    end

    assign avmm_waitrequest   = waitreq_q;
    assign avmm_readdata      = rdata_q;
    assign avmm_readdatavalid = rvalid_q;
    assign err_count          = err_q;

endmodule
